// File: rtl/axis_video_if.sv
// axis_video_if: 24-bit AXI4-Stream video link.
// tdata packs {R,B,G}; tuser marks start of frame and tlast marks end of line.
interface axis_video_if;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/axis_video_source.sv
// axis_video_source: AXI4-Stream test-pattern generator (colour bars, ramp, solid, checkerboard).
// Define AXIS_VIDEO_SOURCE_FRAME_CNT_EN to add the 16-bit frame_count output.
module axis_video_source #(
    parameter int unsigned DIM_W     = 12,
    parameter int unsigned BAR_COUNT = 8
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [1:0]       cfg_pattern,
    input  logic [23:0]      cfg_solid,
    input  logic             start,
    input  logic             free_run,
    axis_video_if.master     m_axis,
    output logic             busy,
    output logic             frame_done,
`ifdef AXIS_VIDEO_SOURCE_FRAME_CNT_EN
    output logic [15:0]      frame_count,
`endif
    output logic             cfg_err
);

    localparam int unsigned ProdW = DIM_W + $clog2(BAR_COUNT + 1);

    typedef enum logic [1:0] {StIdle, StRun, StLast} state_e;

    state_e           state_q, state_d;
    logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
    logic [DIM_W-1:0] width_q, height_q;
    logic [1:0]       pattern_q;
    logic [23:0]      solid_q;
    logic             latch_cfg, done_d, err_d;
    logic             hs, last_x, last_y, fin, cfg_ok;
    logic [DIM_W-1:0] bar_div;
    logic [2:0]       bar_idx;
    logic [23:0]      bar_rbg, pix;

    always_comb begin
        cfg_ok = (cfg_width != '0) && (cfg_height != '0);
        last_x = (x_q == width_q - DIM_W'(1));
        last_y = (y_q == height_q - DIM_W'(1));
        hs     = (state_q != StIdle) && m_axis.tready;
        fin    = hs && last_x && last_y;
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        latch_cfg = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_ok) begin
                        latch_cfg = 1'b1;
                        x_d       = '0;
                        y_d       = '0;
                        state_d   = StRun;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun, StLast: begin
                if (hs) begin
                    x_d = last_x ? '0 : x_q + DIM_W'(1);
                    y_d = last_x ? y_q + DIM_W'(1) : y_q;
                    if (fin) begin
                        x_d    = '0;
                        y_d    = '0;
                        done_d = 1'b1;
                        // Restart re-latches config in the same edge so no idle beat appears.
                        if (free_run && cfg_ok) begin
                            latch_cfg = 1'b1;
                            state_d   = StRun;
                        end else begin
                            err_d   = free_run;
                            state_d = StIdle;
                        end
                    end else if (last_y || (last_x && y_d == height_q - DIM_W'(1))) begin
                        state_d = StLast;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bar_div = (width_q == '0) ? DIM_W'(1) : width_q;
        bar_idx = 3'((ProdW'(x_q) * ProdW'(BAR_COUNT)) / ProdW'(bar_div));
        // Bar colours already in {R,B,G} lane order.
        unique case (bar_idx)
            3'd0: bar_rbg = 24'hFF_FF_FF;
            3'd1: bar_rbg = 24'hFF_00_FF;
            3'd2: bar_rbg = 24'h00_FF_FF;
            3'd3: bar_rbg = 24'h00_00_FF;
            3'd4: bar_rbg = 24'hFF_FF_00;
            3'd5: bar_rbg = 24'hFF_00_00;
            3'd6: bar_rbg = 24'h00_FF_00;
            3'd7: bar_rbg = 24'h00_00_00;
            default: bar_rbg = 24'h00_00_00;
        endcase
        case (pattern_q)
            2'd0:    pix = bar_rbg;
            2'd1:    pix = {3{x_q[7:0]}};
            2'd2:    pix = {solid_q[23:16], solid_q[7:0], solid_q[15:8]};
            default: pix = (x_q[3] ^ y_q[3]) ? 24'hFF_FF_FF : 24'h00_00_00;
        endcase
    end

    always_comb begin
        m_axis.tvalid = (state_q != StIdle);
        busy          = (state_q != StIdle);
        m_axis.tuser  = m_axis.tvalid && (x_q == '0) && (y_q == '0);
        m_axis.tlast  = m_axis.tvalid && last_x;
        m_axis.tdata  = m_axis.tvalid ? pix : 24'h0;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            width_q    <= '0;
            height_q   <= '0;
            pattern_q  <= '0;
            solid_q    <= '0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            frame_done <= done_d;
            cfg_err    <= err_d;
            if (latch_cfg) begin
                width_q   <= cfg_width;
                height_q  <= cfg_height;
                pattern_q <= cfg_pattern;
                solid_q   <= cfg_solid;
            end
        end
    end

`ifdef AXIS_VIDEO_SOURCE_FRAME_CNT_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            frame_count <= '0;
        end else if (done_d) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_video_source.sv
// tb_axis_video_source: directed + randomized checks of axis_video_source against a
// frame-level reference model (expected frames generated from the pattern rules).
module tb_axis_video_source;

    localparam int unsigned DimW     = 12;
    localparam int unsigned BarCount = 8;
    localparam logic [23:0] BarRgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic            aclk = 1'b0;
    logic            areset;
    logic [DimW-1:0] cfg_width, cfg_height;
    logic [1:0]      cfg_pattern;
    logic [23:0]     cfg_solid;
    logic            start, free_run;
    logic            busy, frame_done, cfg_err;
`ifdef AXIS_VIDEO_SOURCE_FRAME_CNT_EN
    logic [15:0]     frame_count;
`endif

    axis_video_if vif();

    axis_video_source #(.DIM_W(DimW), .BAR_COUNT(BarCount)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_pattern(cfg_pattern),
        .cfg_solid  (cfg_solid),
        .start      (start),
        .free_run   (free_run),
        .m_axis     (vif),
        .busy       (busy),
        .frame_done (frame_done),
`ifdef AXIS_VIDEO_SOURCE_FRAME_CNT_EN
        .frame_count(frame_count),
`endif
        .cfg_err    (cfg_err)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;

    // Monitor state (written only by the monitor process).
    int          cyc = 0, done_cnt = 0, err_cnt = 0, valid_cyc = 0;
    int          stall_err = 0, done_err = 0, last_hs_cyc = -10;
    bit          last_hs_tlast = 1'b0, prev_stall = 1'b0, prev_rst = 1'b0;
    logic [25:0] prev_beat = '0;
    logic [23:0] q_data[$];
    bit          q_user[$];
    bit          q_last[$];
    int          user_cyc[$];

    always @(negedge aclk) begin
        cyc <= cyc + 1;
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            if (!(last_hs_cyc == cyc - 1 && last_hs_tlast)) done_err <= done_err + 1;
        end
        if (cfg_err) err_cnt <= err_cnt + 1;
        if (vif.tvalid) valid_cyc <= valid_cyc + 1;
        if (prev_stall && !prev_rst &&
            {vif.tvalid, vif.tdata, vif.tuser, vif.tlast} !== {1'b1, prev_beat})
            stall_err <= stall_err + 1;
        if (vif.tvalid && vif.tready) begin
            q_data.push_back(vif.tdata);
            q_user.push_back(vif.tuser);
            q_last.push_back(vif.tlast);
            if (vif.tuser) user_cyc.push_back(cyc);
            last_hs_cyc   <= cyc;
            last_hs_tlast <= vif.tlast;
        end
        prev_stall <= vif.tvalid && !vif.tready;
        prev_rst   <= areset;
        prev_beat  <= {vif.tdata, vif.tuser, vif.tlast};
    end

    initial begin
        vif.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       vif.tready = 1'b1;
                1:       vif.tready = ~vif.tready;
                default: vif.tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected pixel in {R,B,G} lanes, derived from the RGB colour of each pattern.
    function automatic logic [23:0] exp_pix(int x, int y, int w, int pat, logic [23:0] solid);
        logic [23:0] rgb;
        case (pat)
            0:       rgb = BarRgb[3'(((x * BarCount) / w) % 8)];
            1:       rgb = {3{x[7:0]}};
            2:       rgb = solid;
            default: rgb = ((((x / 8) + (y / 8)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
        endcase
        return {rgb[23:16], rgb[7:0], rgb[15:8]};
    endfunction

    task automatic run_frames(string tag, int w, int h, int pat, logic [23:0] solid,
                              int mode, int nframes);
        int qb    = q_data.size();
        int ub    = user_cyc.size();
        int d0    = done_cnt;
        int se0   = stall_err;
        int de0   = done_err;
        int limit = w * h * nframes * 6 + 50;
        int t     = 0;
        int bad   = 0;
        int nu    = 0;
        int nl    = 0;
        int idx;
        rdy_mode    = mode;
        cfg_width   = DimW'(w);
        cfg_height  = DimW'(h);
        cfg_pattern = 2'(pat);
        cfg_solid   = solid;
        free_run    = (nframes > 1);
        start       = 1'b1;
        step();
        start = 1'b0;
        if (nframes == 1) begin
            cfg_width   = DimW'($urandom_range(1, 50));
            cfg_height  = DimW'($urandom_range(1, 50));
            cfg_pattern = 2'($urandom_range(0, 3));
            cfg_solid   = 24'($urandom());
        end
        while (done_cnt - d0 < nframes && t < limit) begin
            if (done_cnt - d0 >= nframes - 1) free_run = 1'b0;
            step();
            t++;
        end
        free_run = 1'b0;
        check({tag, "_frame_done"}, 64'(done_cnt - d0), 64'(nframes));
        step();
        step();
        check({tag, "_idle_busy"}, 64'(busy), 64'(0));
        check({tag, "_idle_tvalid"}, 64'(vif.tvalid), 64'(0));
        check({tag, "_beats"}, 64'(q_data.size() - qb), 64'(w * h * nframes));
        idx = qb;
        for (int f = 0; f < nframes; f++) begin
            for (int y = 0; y < h; y++) begin
                for (int x = 0; x < w; x++) begin
                    if (idx < q_data.size()) begin
                        if (q_data[idx] !== exp_pix(x, y, w, pat, solid) ||
                            q_user[idx] != (x == 0 && y == 0) || q_last[idx] != (x == w - 1))
                            bad++;
                    end
                    idx++;
                end
            end
        end
        for (int i = qb; i < q_data.size(); i++) begin
            if (q_user[i]) nu++;
            if (q_last[i]) nl++;
        end
        check({tag, "_beat_mismatches"}, 64'(bad), 64'(0));
        check({tag, "_tuser_count"}, 64'(nu), 64'(nframes));
        check({tag, "_tlast_count"}, 64'(nl), 64'(h * nframes));
        check({tag, "_stall_stable"}, 64'(stall_err - se0), 64'(0));
        check({tag, "_done_timing"}, 64'(done_err - de0), 64'(0));
        if (nframes > 1 && mode == 0 && user_cyc.size() >= ub + 2)
            check({tag, "_no_gap"}, 64'(user_cyc[ub + 1] - user_cyc[ub]), 64'(w * h));
    endtask

    initial begin
        int e0, v0, qb, t;
        areset      = 1'b1;
        start       = 1'b0;
        free_run    = 1'b0;
        cfg_width   = '0;
        cfg_height  = '0;
        cfg_pattern = '0;
        cfg_solid   = '0;
        step();
        step();
        check("rst_tvalid", 64'(vif.tvalid), 64'(0));
        check("rst_tuser", 64'(vif.tuser), 64'(0));
        check("rst_tlast", 64'(vif.tlast), 64'(0));
        check("rst_tdata", 64'(vif.tdata), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_frame_done", 64'(frame_done), 64'(0));
        check("rst_cfg_err", 64'(cfg_err), 64'(0));
`ifdef AXIS_VIDEO_SOURCE_FRAME_CNT_EN
        check("rst_frame_count", 64'(frame_count), 64'(0));
`endif
        areset = 1'b0;
        step();

        // Rejected starts: zero width, then zero height.
        e0 = err_cnt;
        v0 = valid_cyc;
        cfg_width  = '0;
        cfg_height = DimW'(5);
        start      = 1'b1;
        step();
        start = 1'b0;
        check("cfgerr_w0_pulse", 64'(cfg_err), 64'(1));
        check("cfgerr_w0_busy", 64'(busy), 64'(0));
        step();
        check("cfgerr_w0_single", 64'(cfg_err), 64'(0));
        cfg_width  = DimW'(5);
        cfg_height = '0;
        start      = 1'b1;
        step();
        start = 1'b0;
        check("cfgerr_h0_pulse", 64'(cfg_err), 64'(1));
        step();
        step();
        check("cfgerr_pulse_count", 64'(err_cnt - e0), 64'(2));
        check("cfgerr_no_tvalid", 64'(valid_cyc - v0), 64'(0));
        check("cfgerr_busy_after", 64'(busy), 64'(0));

        run_frames("toggle_4x2", 4, 2, 1, 24'h0, 1, 1);
        run_frames("w1_h3", 1, 3, 2, 24'($urandom()), 2, 1);
        run_frames("bars_160x120", 160, 120, 0, 24'h0, 0, 1);
        run_frames("checker_20x20", 20, 20, 3, 24'h0, 2, 1);
        for (int i = 0; i < 4; i++) begin
            run_frames("random", $urandom_range(1, 40), $urandom_range(1, 12),
                       $urandom_range(0, 3), 24'($urandom()), 2, 1);
        end

        // Reset in the middle of a width-8 frame.
        qb = q_data.size();
        rdy_mode    = 0;
        cfg_width   = DimW'(8);
        cfg_height  = DimW'(4);
        cfg_pattern = 2'd1;
        start       = 1'b1;
        step();
        start = 1'b0;
        t = 0;
        while (q_data.size() - qb < 5 && t < 50) begin
            step();
            t++;
        end
        check("midreset_reached_beat5", 64'(q_data.size() - qb >= 5), 64'(1));
        areset = 1'b1;
        step();
        areset = 1'b0;
        check("midreset_tvalid", 64'(vif.tvalid), 64'(0));
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_tdata", 64'(vif.tdata), 64'(0));
        step();

        run_frames("freerun_8x4", 8, 4, 3, 24'h0, 0, 2);
`ifdef AXIS_VIDEO_SOURCE_FRAME_CNT_EN
        check("frame_count", 64'(frame_count), 64'(2));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_video_source.md
AXIS_VIDEO_SOURCE -- requirements
Module: axis_video_source

Interface
REQ-001 SHALL have parameter DIM_W, default 12, meaning bit width of width/height config and pixel/line counters.
REQ-002 SHALL have parameter BAR_COUNT, default 8, meaning number of vertical color bars in pattern 0.
REQ-003 SHALL have port aclk, input, 1, meaning the single clock; all logic rising-edge.
REQ-004 SHALL have port areset, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port cfg_width, input, DIM_W, meaning active pixels per line.
REQ-006 SHALL have port cfg_height, input, DIM_W, meaning active lines per frame.
REQ-007 SHALL have port cfg_pattern, input, 2, meaning 0 color bars, 1 horizontal ramp, 2 solid, 3 checkerboard.
REQ-008 SHALL have port cfg_solid, input, 24, meaning RGB value for pattern 2, {R,G,B}.
REQ-009 SHALL have port start, input, 1, meaning begin frame generation (level-sampled in IDLE).
REQ-010 SHALL have port free_run, input, 1, meaning auto-restart next frame after each frame.
REQ-011 SHALL have ports m_axis_tdata (output, 24), m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tuser (output, 1, start of frame), m_axis_tlast (output, 1, end of line).
REQ-012 SHALL have port busy, output, 1, meaning not in IDLE.
REQ-013 SHALL have port frame_done, output, 1, meaning one-cycle pulse on final beat handshake of a frame.
REQ-014 SHALL have port cfg_err, output, 1, meaning one-cycle pulse when start rejected.

Function
REQ-015 SHALL implement states IDLE, RUN, LAST; IDLE->RUN on start with valid config; RUN->LAST on handshake of last line's first pixel when height=1, else when line counter reaches height-1; LAST->IDLE (or RUN if free_run=1) on final-beat handshake.
REQ-016 SHALL latch cfg_width, cfg_height, cfg_pattern, cfg_solid at each frame start; changes mid-frame SHALL not affect the current frame.
REQ-017 SHALL reject start when cfg_width=0 or cfg_height=0: remain IDLE, pulse cfg_err next cycle.
REQ-018 SHALL assert m_axis_tvalid one cycle after leaving IDLE and keep it high continuously until the final beat of the frame is accepted.
REQ-019 SHALL hold tdata, tuser, tlast stable while tvalid=1 and tready=0.
REQ-020 SHALL advance pixel counter x only on tvalid&tready; x wraps to 0 after width-1, incrementing line counter y.
REQ-021 SHALL assert tuser only on beat (x=0,y=0); tlast only on beat x=width-1; width=1 asserts tlast every beat, with tuser on the first.
REQ-022 SHALL pack tdata as [23:16]=R, [15:8]=B, [7:0]=G.
REQ-023 SHALL compute pattern 0 bar index = (x*BAR_COUNT)/width, colors cycling white, yellow, cyan, green, magenta, red, blue, black.
REQ-024 SHALL compute pattern 1 as R=G=B=x[7:0]; pattern 3 as white when x[3]^y[3]=1, else black.
REQ-025 SHALL in free_run produce back-to-back frames with no idle cycle between final beat and next tuser beat.
REQ-026 SHALL, when free_run drops mid-frame, complete the current frame then return to IDLE.
REQ-027 SHALL pulse frame_done exactly on the cycle after the final-beat handshake.

Reset
REQ-028 SHALL on areset=1 at a clock edge force IDLE, x=y=0, tvalid=0, tuser=0, tlast=0, tdata=0, busy=0, frame_done=0, cfg_err=0.
REQ-029 SHALL apply reset mid-frame without completing the frame; tvalid low the cycle after reset is sampled.

Configuration
REQ-030 SHALL, when macro AXIS_VIDEO_SOURCE_FRAME_CNT_EN is defined, provide output frame_count (16 bits), reset 0, incremented on each frame_done and wrapping 65535->0.
REQ-031 SHALL, without AXIS_VIDEO_SOURCE_FRAME_CNT_EN, omit frame_count port and its logic entirely.

Verification
REQ-032 SHALL test width=800, height=600, pattern 0, tready=1 -> 480000 beats, 600 tlast, 1 tuser, frame_done once.
REQ-033 SHALL test width=4, height=2, tready toggling 1/0 every cycle -> exactly 8 beats, data stable during stalls, tlast at beats 4 and 8.
REQ-034 SHALL test width=1, height=3 -> 3 beats each with tlast, tuser on first only.
REQ-035 SHALL test cfg_width=0 with start=1 -> cfg_err pulses, busy stays 0, tvalid stays 0.
REQ-036 SHALL test free_run=1, width=8, height=4 -> two consecutive frames with no gap; with the macro, frame_count=2.
REQ-037 SHALL test areset asserted at beat 5 of width=8 frame -> tvalid=0 next cycle, next start produces tuser at x=0,y=0.
